partsel_window_arbiter: RTL and testbench

- Owns one bit-vector register declared `[MSB:LSB]`, which may be little- or big-endian and may have negative bounds.
- Shares indexed part-select access (`reg[sel +: W]`) between NREQ requesters through a round-robin arbiter, at most one access per cycle.
- Each granted access gets a registered response.
- A clear sequencer zeroes the register in W-bit chunks on demand.
- Sits between bus-side requesters and any bit-field state that needs variable-offset read/write.

---
 rtl/partsel_sched_pkg.sv | 31 +++
 rtl/partsel_window_arbiter_rr_arbiter.sv | 34 +++
 rtl/partsel_window_arbiter.sv | 136 +++++++++++++
 tb/tb_partsel_window_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/partsel_sched_pkg.sv
// partsel_sched_pkg: shared FSM state, window-to-physical-bit mapping and ceil_div helper
// Ports: none (package)
package partsel_sched_pkg;

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    // One window bit: physical position (offset from the rightmost declared bit) and in-range flag
    typedef struct packed {
        logic ok;
        int   pos;
    } win_bit_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Window bit j follows reg[sel +: w]: little-endian puts bit j at index sel+j,
    // big-endian puts bit w-1 at index sel, so bit j sits at index sel+(w-1-j).
    function automatic win_bit_t win_map(input int sel, input int msb, input int lsb,
                                         input int w, input int j);
        win_bit_t r;
        int idx;
        int n;
        idx   = (msb >= lsb) ? sel + j : sel + (w - 1 - j);
        r.pos = (msb >= lsb) ? idx - lsb : lsb - idx;
        n     = (msb >= lsb) ? msb - lsb + 1 : lsb - msb + 1;
        r.ok  = (r.pos >= 0) && (r.pos < n);
        return r;
    endfunction

endpackage

// File: rtl/partsel_window_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with its own rotating pointer
// Ports: clk, rst; en_i enables granting; elig_i eligible requesters; gnt_o one-hot grant or zero
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [NREQ-1:0] elig_i,
    output logic [NREQ-1:0] gnt_o
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;

    // Scan offsets from the pointer outward; the first eligible requester wins
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int o = 0; o < NREQ; o++)
            for (int i = 0; i < NREQ; i++)
                if (en_i && !found && elig_i[i] && i == (int'(ptr_q) + o) % NREQ) begin
                    gnt_o[i] = 1'b1;
                    ptr_d    = PW'((i + 1) % NREQ);
                    found    = 1'b1;
                end
    end

    always_ff @(posedge clk)
        ptr_q <= rst ? '0 : ptr_d;

endmodule

// File: rtl/partsel_window_arbiter.sv
// partsel_window_arbiter: round-robin shared reg[sel +: W] access with registered responses and chunked clear
// Ports: clk, rst; req_* request channel per requester (valid/ready/we/sel/wdata);
//        rsp_* response slot per requester (valid/ready/rdata/oob); clear_start/clear_busy sweep control;
//        data_q current register contents declared [MSB:LSB]
module partsel_window_arbiter
    import partsel_sched_pkg::*;
#(
    parameter int MSB   = 6,
    parameter int LSB   = 0,
    parameter int W     = 2,
    parameter int NREQ  = 2,
    parameter int SEL_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*SEL_W-1:0] req_sel,
    input  logic [NREQ*W-1:0]     req_wdata,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [NREQ*W-1:0]     rsp_rdata,
    output logic [NREQ-1:0]       rsp_oob,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic [MSB:LSB]        data_q
);
    localparam int N   = MSB >= LSB ? MSB - LSB + 1 : LSB - MSB + 1;
    localparam int NCH = ceil_div(N, W);
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;

    state_t              state_q, state_d;
    logic [CW-1:0]       k_q, k_d;
    logic [N-1:0]        bits_q, bits_d;
    logic [NREQ-1:0]     elig, gnt, arb_unused_n;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d, rsp_oob_q, rsp_oob_d;
    logic [NREQ*W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [SEL_W-1:0]    g_sel;
    logic                g_we, win_oob, arb_en;
    logic [W-1:0]        g_wdata, win_rd;
    win_bit_t            wb;

    // A full slot may be reloaded in the same cycle it is being consumed
    assign elig   = req_valid & (~rsp_valid_q | rsp_ready);
    assign arb_en = (state_q == IDLE) && !clear_start;
    assign arb_unused_n = '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en_i  (arb_en),
        .elig_i(elig),
        .gnt_o (gnt)
    );

    always_comb begin
        g_sel   = '0;
        g_we    = 1'b0;
        g_wdata = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) begin
                g_sel   = req_sel[i*SEL_W +: SEL_W];
                g_we    = req_we[i];
                g_wdata = req_wdata[i*W +: W];
            end
    end

    // Window read/write and clear chunk, matched per physical bit to avoid wide dynamic indexing
    always_comb begin
        win_rd  = '0;
        win_oob = 1'b0;
        bits_d  = bits_q;
        wb      = '0;
        for (int j = 0; j < W; j++) begin
            wb      = win_map(int'(g_sel), MSB, LSB, W, j);
            win_oob = win_oob | !wb.ok;
            for (int p = 0; p < N; p++)
                if (wb.ok && wb.pos == p) begin
                    win_rd[j] = bits_q[p];
                    if (g_we) bits_d[p] = g_wdata[j];
                end
        end
        if (state_q == CLEAR)
            for (int p = 0; p < N; p++)
                if (p / W == int'(k_q)) bits_d[p] = 1'b0;
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_oob_d   = rsp_oob_q;
        rsp_rdata_d = rsp_rdata_q;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) begin
                rsp_valid_d[i]         = 1'b1;
                rsp_oob_d[i]           = win_oob;
                rsp_rdata_d[i*W +: W]  = win_rd;
            end
        if (state_q == IDLE && clear_start) begin
            state_d = CLEAR;
            k_d     = '0;
        end
        if (state_q == CLEAR) begin
            k_d     = k_q == CW'(NCH - 1) ? '0 : k_q + 1'b1;
            state_d = k_q == CW'(NCH - 1) ? IDLE : CLEAR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            bits_q      <= '0;
            rsp_valid_q <= '0;
            rsp_oob_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            bits_q      <= bits_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_oob_q   <= rsp_oob_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready  = gnt | arb_unused_n;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_oob    = rsp_oob_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign clear_busy = state_q == CLEAR;
    assign data_q     = bits_q;

endmodule

// File: tb/tb_partsel_window_arbiter.sv
// tb_partsel_window_arbiter: directed checks over little-endian, negative-bound and big-endian instances
module tb_partsel_window_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] a_valid, a_we, a_rrdy, a_ready, a_rvalid, a_oob;
    logic [5:0] a_sel;
    logic [3:0] a_wdata, a_rdata;
    logic       a_cs, a_busy;
    logic [4:-2] a_data;

    logic [1:0] b_valid, b_we, b_rrdy, b_ready, b_rvalid, b_oob;
    logic [5:0] b_sel;
    logic [3:0] b_wdata, b_rdata;
    logic       b_cs, b_busy;
    logic [0:6] b_data;

    logic [1:0] c_valid, c_we, c_rrdy, c_ready, c_rvalid, c_oob;
    logic [5:0] c_sel;
    logic [3:0] c_wdata, c_rdata;
    logic       c_cs, c_busy;
    logic [6:0] c_data;

    partsel_window_arbiter #(.MSB(4), .LSB(-2), .W(2), .NREQ(2), .SEL_W(3)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_sel(a_sel), .req_wdata(a_wdata), .rsp_valid(a_rvalid), .rsp_ready(a_rrdy),
        .rsp_rdata(a_rdata), .rsp_oob(a_oob), .clear_start(a_cs), .clear_busy(a_busy), .data_q(a_data)
    );

    partsel_window_arbiter #(.MSB(0), .LSB(6), .W(2), .NREQ(2), .SEL_W(3)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_sel(b_sel), .req_wdata(b_wdata), .rsp_valid(b_rvalid), .rsp_ready(b_rrdy),
        .rsp_rdata(b_rdata), .rsp_oob(b_oob), .clear_start(b_cs), .clear_busy(b_busy), .data_q(b_data)
    );

    partsel_window_arbiter #(.MSB(6), .LSB(0), .W(2), .NREQ(2), .SEL_W(3)) u_c (
        .clk(clk), .rst(rst), .req_valid(c_valid), .req_ready(c_ready), .req_we(c_we),
        .req_sel(c_sel), .req_wdata(c_wdata), .rsp_valid(c_rvalid), .rsp_ready(c_rrdy),
        .rsp_rdata(c_rdata), .rsp_oob(c_oob), .clear_start(c_cs), .clear_busy(c_busy), .data_q(c_data)
    );

    logic [1:0] arb_exp [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    logic [2:0] fill_sel [4] = '{3'd0, 3'd2, 3'd4, 3'd6};

    initial begin
        {a_valid, a_we, a_rrdy, a_sel, a_wdata, a_cs} = '0;
        {b_valid, b_we, b_rrdy, b_sel, b_wdata, b_cs} = '0;
        {c_valid, c_we, c_rrdy, c_sel, c_wdata, c_cs} = '0;
        step();
        step();
        check("rst_data", c_data, 7'h00);
        check("rst_rvalid", c_rvalid, 2'b00);
        check("rst_rdata", c_rdata, 4'h0);
        check("rst_oob", c_oob, 2'b00);
        check("rst_busy", c_busy, 1'b0);
        check("rst_ready", c_ready, 2'b00);
        rst = 1'b0;

        // Negative LSB: write then read back sel=3
        a_valid = 2'b01; a_we = 2'b01; a_sel = {3'd0, 3'd3}; a_wdata = {2'b00, 2'b10}; a_rrdy = 2'b11;
        #1 check("a_wr_ready", a_ready, 2'b01);
        step();
        check("a_wr_data", a_data, 7'h40);
        check("a_wr_oob", a_oob[0], 1'b0);
        check("a_wr_rvalid", a_rvalid[0], 1'b1);
        a_we = 2'b00;
        step();
        check("a_rd_rdata", a_rdata[1:0], 2'b10);
        check("a_rd_rvalid", a_rvalid[0], 1'b1);
        a_valid = 2'b00;

        // Big-endian [0:6]
        b_valid = 2'b01; b_we = 2'b01; b_sel = {3'd0, 3'd2}; b_wdata = {2'b00, 2'b10}; b_rrdy = 2'b11;
        step();
        check("b_wr2_data", b_data, 7'h10);
        check("b_wr2_oob", b_oob[0], 1'b0);
        b_sel = {3'd0, 3'd6}; b_wdata = {2'b00, 2'b11};
        step();
        check("b_wr6_data", b_data, 7'h11);
        check("b_wr6_oob", b_oob[0], 1'b1);
        b_valid = 2'b00;

        // Little-endian partial and full out-of-range windows
        c_valid = 2'b01; c_we = 2'b01; c_sel = {3'd0, 3'd6}; c_wdata = {2'b00, 2'b01}; c_rrdy = 2'b11;
        step();
        check("c_wr6_data", c_data, 7'h40);
        check("c_wr6_oob", c_oob[0], 1'b1);
        c_we = 2'b00;
        step();
        check("c_rd6_rdata", c_rdata[1:0], 2'b01);
        check("c_rd6_oob", c_oob[0], 1'b1);
        c_sel = {3'd0, 3'd7};
        step();
        check("c_rd7_rdata", c_rdata[1:0], 2'b00);
        check("c_rd7_oob", c_oob[0], 1'b1);
        check("c_rd7_data", c_data, 7'h40);
        c_valid = 2'b00;

        rst = 1'b1;
        step();
        rst = 1'b0;
        check("c_rst2_data", c_data, 7'h00);

        // Round robin, then requester 0 blocked by its unconsumed response
        c_valid = 2'b11; c_we = 2'b00; c_sel = '0; c_rrdy = 2'b11;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) c_rrdy = 2'b10;
            #1 check($sformatf("arb_%0d", k), c_ready, arb_exp[k]);
            step();
        end

        // Fill all bits through requester 0
        c_valid = 2'b01; c_we = 2'b01; c_rrdy = 2'b11; c_wdata = {2'b00, 2'b11};
        for (int s = 0; s < 4; s++) begin
            c_sel = {3'd0, fill_sel[s]};
            step();
        end
        check("fill_data", c_data, 7'h7F);

        // Leave a response pending on requester 1, then clear
        c_valid = 2'b10; c_we = 2'b00; c_rrdy = 2'b01;
        step();
        c_valid = 2'b11; c_rrdy = 2'b00; c_cs = 1'b1;
        #1 check("clr_start_ready", c_ready, 2'b00);
        step();
        c_cs = 1'b0; c_rrdy = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("clr_busy_%0d", k), c_busy, 1'b1);
            check($sformatf("clr_ready_%0d", k), c_ready, 2'b00);
            if (k == 0) check("clr_rvalid_pend", c_rvalid[1], 1'b1);
            if (k == 1) begin
                check("clr_rvalid_drain", c_rvalid[1], 1'b0);
                check("clr_chunk0", c_data, 7'h7C);
            end
            step();
        end
        #1 check("clr_done_busy", c_busy, 1'b0);
        check("clr_done_data", c_data, 7'h00);
        c_valid = 2'b00;
        step();

        // Reset during the second clear cycle with a pending response
        c_valid = 2'b01; c_we = 2'b01; c_sel = {3'd0, 3'd4}; c_wdata = {2'b00, 2'b11}; c_rrdy = 2'b00;
        step();
        c_valid = 2'b00; c_cs = 1'b1;
        step();
        c_cs = 1'b0;
        step();
        check("rc_busy_pre", c_busy, 1'b1);
        check("rc_data_pre", c_data, 7'h30);
        check("rc_rvalid_pre", c_rvalid[0], 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rc_busy", c_busy, 1'b0);
        check("rc_rvalid", c_rvalid, 2'b00);
        check("rc_data", c_data, 7'h00);
        c_valid = 2'b11; c_we = 2'b00;
        #1 check("rc_ptr", c_ready, 2'b01);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
